// File: rtl/tile_fetch_if.sv
// Renderer-side channel of the tile fetch unit: pixel request handshake and pixel response stream.
interface tile_fetch_if #(
   parameter int unsigned TILE_W_LOG2   = 2,
   parameter int unsigned TILE_H_LOG2   = 2,
   parameter int unsigned TILE_CNT_LOG2 = 4,
   parameter int unsigned DATA_W        = 24
);
   logic                     i_req_valid;
   logic                     o_req_ready;
   logic [TILE_CNT_LOG2-1:0] i_tile_no;
   logic [TILE_W_LOG2-1:0]   i_tile_x;
   logic [TILE_H_LOG2-1:0]   i_tile_y;
   logic [1:0]               i_mirror;
   logic [1:0]               i_rotate;
   logic [DATA_W-1:0]        o_rgb_data;
   logic                     o_valid;
   logic                     i_ready;

   // Renderer side: issues requests, consumes pixels
   modport master (
      output i_req_valid, i_tile_no, i_tile_x, i_tile_y, i_mirror, i_rotate, i_ready,
      input  o_req_ready, o_rgb_data, o_valid
   );

   // Fetch unit side
   modport slave (
      input  i_req_valid, i_tile_no, i_tile_x, i_tile_y, i_mirror, i_rotate, i_ready,
      output o_req_ready, o_rgb_data, o_valid
   );
endinterface

// File: rtl/tile_fetch.sv
// Tile-pixel fetch unit: maps (tile, x, y, mirror, rotate) to a tile-ROM address, issues the read,
// and returns pixels in request order through a credit-protected response FIFO.
module tile_fetch #(
   parameter int unsigned TILE_W_LOG2   = 2,
   parameter int unsigned TILE_H_LOG2   = 2,
   parameter int unsigned TILE_CNT_LOG2 = 4,
   parameter int unsigned ROM_ADDR_W    = 9,
   parameter int unsigned DATA_W        = 24,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   tile_fetch_if.slave           px_if,
   output logic [ROM_ADDR_W-1:0] o_rom_address,
   output logic                  o_rom_read,
   input  logic [DATA_W-1:0]     i_rom_data,
   input  logic                  i_rom_valid,
   output logic                  o_busy
);
   localparam int unsigned XW    = TILE_W_LOG2;
   localparam int unsigned YW    = TILE_H_LOG2;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned INF_W = CNT_W + 1;
   localparam bit          SQUARE = (TILE_W_LOG2 == TILE_H_LOG2);

   logic                  rom_read_q,  rom_read_d;
   logic [ROM_ADDR_W-1:0] rom_addr_q,  rom_addr_d;
   logic [CNT_W-1:0]      out_cnt_q,   out_cnt_d;
   logic [CNT_W-1:0]      fifo_cnt_q,  fifo_cnt_d;
   logic [PTR_W-1:0]      wr_ptr_q,    wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q,    rd_ptr_d;
   logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];

   logic [XW-1:0]         sx_c;
   logic [YW-1:0]         sy_c;
   logic [ROM_ADDR_W-1:0] addr_c;
   logic [INF_W-1:0]      inflight_c;
   logic                  accept_c;
   logic                  push_c;
   logic                  pop_c;

   // In-flight credits: pending address-stage read + outstanding ROM reads + buffered pixels
   assign inflight_c = INF_W'(rom_read_q) + INF_W'(out_cnt_q) + INF_W'(fifo_cnt_q);

   assign px_if.o_req_ready = i_rst_n && (inflight_c < INF_W'(FIFO_DEPTH));
   assign accept_c          = px_if.i_req_valid && px_if.o_req_ready;
   assign px_if.o_valid     = (fifo_cnt_q != '0);
   assign px_if.o_rgb_data  = mem_q[rd_ptr_q];
   assign o_rom_address     = rom_addr_q;
   assign o_rom_read        = rom_read_q;
   assign o_busy            = (inflight_c != '0);

   // Source coordinate: rotation (square tiles only) then mirror; N-1-v is the bitwise complement
   always_comb begin
      sx_c = px_if.i_tile_x;
      sy_c = px_if.i_tile_y;
      if (SQUARE) begin
         case (px_if.i_rotate)
            2'd1: begin
               sx_c = XW'(px_if.i_tile_y);
               sy_c = YW'(~px_if.i_tile_x);
            end
            2'd2: begin
               sx_c = ~px_if.i_tile_x;
               sy_c = ~px_if.i_tile_y;
            end
            2'd3: begin
               sx_c = XW'(~px_if.i_tile_y);
               sy_c = YW'(px_if.i_tile_x);
            end
            default: ;
         endcase
      end
      if (px_if.i_mirror[0]) sy_c = ~sy_c;
      if (px_if.i_mirror[1]) sx_c = ~sx_c;
      addr_c = ROM_ADDR_W'({px_if.i_tile_no, sy_c, sx_c});
   end

   // Next-state for address stage, outstanding-read counter and FIFO pointers
   always_comb begin
      rom_read_d = 1'b0;
      rom_addr_d = rom_addr_q;
      if (accept_c) begin
         rom_read_d = 1'b1;
         rom_addr_d = addr_c;
      end
      // A return with nothing outstanding is stale (e.g. issued before reset) and is dropped
      push_c     = i_rom_valid && (out_cnt_q != '0);
      pop_c      = (fifo_cnt_q != '0) && px_if.i_ready;
      out_cnt_d  = out_cnt_q + CNT_W'(rom_read_q) - CNT_W'(push_c);
      fifo_cnt_d = fifo_cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
      wr_ptr_d   = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
   end

   // Control state registers
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rom_read_q <= 1'b0;
         rom_addr_q <= '0;
         out_cnt_q  <= '0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         rom_read_q <= rom_read_d;
         rom_addr_q <= rom_addr_d;
         out_cnt_q  <= out_cnt_d;
         fifo_cnt_q <= fifo_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Response FIFO storage; cleared so the head reads zero out of reset
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      end else if (push_c) begin
         mem_q[wr_ptr_q] <= i_rom_data;
      end
   end
endmodule

// File: tb/tb_tile_fetch.sv
// Directed bench for tile_fetch: W=H=4, 16 tiles, 1-cycle ROM model, FIFO depth 4.
module tb_tile_fetch;
   localparam int unsigned AW = 9;
   localparam int unsigned DW = 24;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] rom_address;
   logic          rom_read;
   logic [DW-1:0] rom_data  = '0;
   logic          rom_valid = 1'b0;
   logic          busy;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   logic [DW-1:0] got_q[$];
   int            pop_cyc[$];

   tile_fetch_if #(.TILE_W_LOG2(2), .TILE_H_LOG2(2), .TILE_CNT_LOG2(4), .DATA_W(DW)) px_if ();

   tile_fetch #(
      .TILE_W_LOG2(2), .TILE_H_LOG2(2), .TILE_CNT_LOG2(4),
      .ROM_ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .px_if(px_if),
      .o_rom_address(rom_address),
      .o_rom_read(rom_read),
      .i_rom_data(rom_data),
      .i_rom_valid(rom_valid),
      .o_busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ROM content: distinct word per address
   function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
      return 24'hA50000 ^ {15'd0, a};
   endfunction

   // One-cycle-latency ROM model (not reset, so a late response survives a DUT reset)
   always @(posedge clk) begin
      rom_valid <= rom_read;
      rom_data  <= rom_fn(rom_address);
   end

   // Record every popped pixel and the cycle it left
   always @(negedge clk) begin
      if (rst_n && px_if.o_valid && px_if.i_ready) begin
         got_q.push_back(px_if.o_rgb_data);
         pop_cyc.push_back(cyc);
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input int t, input int x, input int y, input int m, input int r);
      px_if.i_tile_no   = 4'(t);
      px_if.i_tile_x    = 2'(x);
      px_if.i_tile_y    = 2'(y);
      px_if.i_mirror    = 2'(m);
      px_if.i_rotate    = 2'(r);
      px_if.i_req_valid = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      px_if.i_ready = 1'b0;
      drive_req(0, 0, 0, 0, 0);
      tick;
      tick;
      n_checks++; if (px_if.o_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", px_if.o_req_ready); end
      n_checks++; if (px_if.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", px_if.o_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (rom_read !== 1'b0) begin n_fail++; $display("FAIL reset_rom_read: got %b want 0", rom_read); end
      n_checks++; if (rom_address !== 9'd0) begin n_fail++; $display("FAIL reset_rom_address: got %0d want 0", rom_address); end
      n_checks++; if (px_if.o_rgb_data !== 24'h0) begin n_fail++; $display("FAIL reset_rgb: got %h want 000000", px_if.o_rgb_data); end
      px_if.i_req_valid = 1'b0;
      rst_n = 1'b1;
      tick;
      n_checks++; if (px_if.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", px_if.o_req_ready); end
   endtask

   task automatic test_basic;
      px_if.i_ready = 1'b1;
      drive_req(3, 1, 2, 0, 0);
      n_checks++; if (px_if.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", px_if.o_req_ready); end
      tick;
      px_if.i_req_valid = 1'b0;
      n_checks++; if (rom_read !== 1'b1) begin n_fail++; $display("FAIL basic_rom_read: got %b want 1", rom_read); end
      n_checks++; if (rom_address !== 9'd57) begin n_fail++; $display("FAIL basic_addr: got %0d want 57", rom_address); end
      tick;
      n_checks++; if (rom_read !== 1'b0) begin n_fail++; $display("FAIL basic_read_pulse: got %b want 0", rom_read); end
      n_checks++; if (px_if.o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %b want 0", px_if.o_valid); end
      tick;
      n_checks++; if (px_if.o_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", px_if.o_valid); end
      n_checks++; if (px_if.o_rgb_data !== 24'hA50039) begin n_fail++; $display("FAIL basic_data: got %h want a50039", px_if.o_rgb_data); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
      tick;
      n_checks++; if (px_if.o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_popped: got %b want 0", px_if.o_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b want 0", busy); end
   endtask

   task automatic test_mirror;
      int            m_tab [3] = '{1, 2, 3};
      int            a_tab [3] = '{53, 58, 54};
      logic [DW-1:0] d_tab [3] = '{24'hA50035, 24'hA5003A, 24'hA50036};
      px_if.i_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive_req(3, 1, 2, m_tab[k], 0);
         tick;
         px_if.i_req_valid = 1'b0;
         n_checks++; if (rom_address !== 9'(a_tab[k])) begin n_fail++; $display("FAIL mirror%0d_addr: got %0d want %0d", m_tab[k], rom_address, a_tab[k]); end
         tick;
         tick;
         n_checks++; if (px_if.o_valid !== 1'b1 || px_if.o_rgb_data !== d_tab[k]) begin n_fail++; $display("FAIL mirror%0d_data: got v=%b %h want v=1 %h", m_tab[k], px_if.o_valid, px_if.o_rgb_data, d_tab[k]); end
         tick;
      end
   endtask

   task automatic test_rotate;
      int            r_tab [4] = '{1, 1, 2, 3};
      int            m_tab [4] = '{0, 2, 0, 0};
      int            a_tab [4] = '{8, 11, 14, 7};
      logic [DW-1:0] d_tab [4] = '{24'hA50008, 24'hA5000B, 24'hA5000E, 24'hA50007};
      px_if.i_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive_req(0, 1, 0, m_tab[k], r_tab[k]);
         tick;
         px_if.i_req_valid = 1'b0;
         n_checks++; if (rom_address !== 9'(a_tab[k])) begin n_fail++; $display("FAIL rot%0d_m%0d_addr: got %0d want %0d", r_tab[k], m_tab[k], rom_address, a_tab[k]); end
         tick;
         tick;
         n_checks++; if (px_if.o_valid !== 1'b1 || px_if.o_rgb_data !== d_tab[k]) begin n_fail++; $display("FAIL rot%0d_m%0d_data: got v=%b %h want v=1 %h", r_tab[k], m_tab[k], px_if.o_valid, px_if.o_rgb_data, d_tab[k]); end
         tick;
      end
   endtask

   task automatic test_backpressure;
      int   sent = 0;
      logic acc;
      got_q.delete();
      pop_cyc.delete();
      px_if.i_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         drive_req(sent + 1, sent % 4, (sent + 2) % 4, 0, 0);
         acc = px_if.o_req_ready;
         tick;
         if (acc) sent++;
      end
      n_checks++; if (sent !== 4) begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", sent); end
      n_checks++; if (px_if.o_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", px_if.o_req_ready); end
      n_checks++; if (px_if.o_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_full: got v=%b busy=%b want 1 1", px_if.o_valid, busy); end
      n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL bp_no_pop: got %0d pops want 0", got_q.size()); end
      px_if.i_ready = 1'b1;
      for (int c = 0; c < 40 && got_q.size() < 6; c++) begin
         if (sent < 6) drive_req(sent + 1, sent % 4, (sent + 2) % 4, 0, 0);
         else px_if.i_req_valid = 1'b0;
         acc = px_if.i_req_valid && px_if.o_req_ready;
         tick;
         if (acc) sent++;
      end
      px_if.i_req_valid = 1'b0;
      n_checks++; if (sent !== 6) begin n_fail++; $display("FAIL bp_total_accepted: got %0d want 6", sent); end
      n_checks++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL bp_drain_count: got %0d want 6", got_q.size()); end
      for (int i = 0; i < 6 && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== rom_fn(9'((i + 1) * 16 + ((i + 2) % 4) * 4 + (i % 4)))) begin
            n_fail++;
            $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], rom_fn(9'((i + 1) * 16 + ((i + 2) % 4) * 4 + (i % 4))));
         end
      end
      tick;
   endtask

   task automatic test_back_to_back;
      int   sent   = 0;
      int   stalls = 0;
      logic acc;
      got_q.delete();
      pop_cyc.delete();
      px_if.i_ready = 1'b1;
      for (int c = 0; c < 40 && sent < 16; c++) begin
         drive_req(sent, sent % 4, sent / 4, 0, 0);
         acc = px_if.o_req_ready;
         if (!acc) stalls++;
         tick;
         if (acc) sent++;
      end
      px_if.i_req_valid = 1'b0;
      for (int c = 0; c < 20 && got_q.size() < 16; c++) tick;
      n_checks++; if (stalls !== 0) begin n_fail++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
      n_checks++; if (got_q.size() !== 16) begin n_fail++; $display("FAIL b2b_count: got %0d want 16", got_q.size()); end
      for (int i = 0; i < 16 && i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== rom_fn(9'(17 * i)) || pop_cyc[i] !== pop_cyc[0] + i) begin
            n_fail++;
            $display("FAIL b2b_pix[%0d]: got %h at +%0d want %h at +%0d", i, got_q[i], pop_cyc[i] - pop_cyc[0], rom_fn(9'(17 * i)), i);
         end
      end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", busy); end
   endtask

   task automatic test_reset_midstream;
      px_if.i_ready = 1'b1;
      drive_req(5, 0, 0, 0, 0);
      tick;
      drive_req(6, 0, 0, 0, 0);
      tick;
      px_if.i_req_valid = 1'b0;
      rst_n = 1'b0;
      tick;
      n_checks++; if (px_if.o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", px_if.o_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
      n_checks++; if (rom_read !== 1'b0) begin n_fail++; $display("FAIL mid_reset_read: got %b want 0", rom_read); end
      rst_n = 1'b1;
      got_q.delete();
      tick;
      n_checks++; if (px_if.o_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL late_rsp_dropped: got v=%b busy=%b want 0 0", px_if.o_valid, busy); end
      n_checks++; if (px_if.o_req_ready !== 1'b1) begin n_fail++; $display("FAIL late_rsp_credits: got %b want 1", px_if.o_req_ready); end
      drive_req(7, 2, 1, 0, 0);
      tick;
      px_if.i_req_valid = 1'b0;
      n_checks++; if (rom_address !== 9'd118) begin n_fail++; $display("FAIL post_reset_addr: got %0d want 118", rom_address); end
      tick;
      tick;
      n_checks++; if (px_if.o_valid !== 1'b1 || px_if.o_rgb_data !== 24'hA50076) begin n_fail++; $display("FAIL post_reset_data: got v=%b %h want v=1 a50076", px_if.o_valid, px_if.o_rgb_data); end
      tick;
      n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL post_reset_count: got %0d want 1", got_q.size()); end
   endtask

   // Hard stop if the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      px_if.i_req_valid = 1'b0;
      px_if.i_tile_no   = '0;
      px_if.i_tile_x    = '0;
      px_if.i_tile_y    = '0;
      px_if.i_mirror    = '0;
      px_if.i_rotate    = '0;
      px_if.i_ready     = 1'b0;
      rst_n             = 1'b0;
      test_reset;
      test_basic;
      test_mirror;
      test_rotate;
      test_backpressure;
      test_back_to_back;
      test_reset_midstream;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
